timing_sequencer: RTL and testbench
===================================

# timing_sequencer

Parametrised timing-signal generator for the common-bus control path. It holds the sequence counter and decodes it into one-hot T states, and decodes the opcode into one-hot D lines. It also owns the interrupt-cycle flag R, a HALT state, and an optional memory wait-state handshake with timeout. It sits between the control-logic gates and the memory/flag registers, and replaces the fixed 4-bit counter and decoder pair.

## Interface
- SC_WIDTH, 4, sequence-counter width; NUM_T = 2**SC_WIDTH timing lines
- OPC_WIDTH, 3, opcode width; NUM_D = 2**OPC_WIDTH decode lines
- MAX_WAIT, 8, maximum wait-state cycles before bus error (≥2)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inc  in  1  advance SC
- clr  in  1  clear SC to 0 (end of instruction / interrupt cycle)
- halt_req  in  1  enter HALT (HLT instruction)
- run  in  1  leave HALT
- mem_req  in  1  memory access issued in current T state
- mem_ready  in  1  memory access complete
- ien, fgi, fgo  in  1 each  interrupt enable, input flag, output flag
- opcode  in  OPC_WIDTH  IR opcode field
- t  out  NUM_T  one-hot timing state
- d  out  NUM_D  one-hot opcode decode
- count  out  SC_WIDTH  raw SC value
- r  out  1  interrupt-cycle flag
- stall  out  1  control logic must suppress all loads/writes
- halted  out  1  in HALT
- overflow  out  1  sticky: SC wrapped without clr
- bus_err  out  1  sticky: wait-state timeout

## Operation
- States: RUN, WAIT, HALT.
- RUN priority: halt_req > memory stall > clr > inc.
  - halt_req: go to HALT, SC=0.
  - mem_req & !mem_ready: go to WAIT, SC holds.
  - clr: SC=0.
  - inc: SC=SC+1.
- WAIT:
  - mem_ready: return to RUN, applying the inc/clr present in that cycle.
  - Otherwise the wait counter increments.
  - When MAX_WAIT cycles elapse without mem_ready: go to HALT, SC=0, bus_err=1.
- HALT: SC frozen at 0, t all zeros. `run` returns to RUN with SC=0.
- Wrap: inc at SC=NUM_T-1 gives SC=0 and sets overflow. overflow is cleared only by reset.
- R set:
  - Condition: RUN, not stalled, r=0, count≥3, ien & (fgi|fgo).
  - Effect: r takes 1 on the next edge.
- R clear: clr asserted while r=1 (RT2 end of interrupt cycle), in RUN and not stalled.
- stall = (state==WAIT) | (state==RUN & mem_req & !mem_ready). It is combinational.
- d: pure decode of opcode, never gated.
- t: decode of count, forced to zero in HALT.

## Timing
- Reset values:
  - count=0 and t=1 (T0).
  - state RUN: r=0, halted=0, overflow=0, bus_err=0, stall=0.
  - d follows opcode.
- count, r, halted, overflow and bus_err are registered and change one cycle after the causing input.
- t follows count combinationally.
- halted=1 on the edge after halt_req or timeout. It deasserts on the edge after run.
- Wait handshake: mem_ready sampled in the request cycle means zero wait states.
- Each missing ready cycle adds exactly one cycle of stall with t unchanged.
- Simultaneous clr and inc: clr wins.
- Simultaneous halt_req and mem_req: halt wins and the access is abandoned.
- run with halt_req in the same HALT cycle: stay in HALT.
- Reset mid-WAIT or mid-HALT: immediate return to reset values. The wait counter is cleared.

## Configuration
- TIMING_WAIT_STATE_EN defined: WAIT state, wait counter, MAX_WAIT timeout and bus_err are present.
- Not defined:
  - mem_req and mem_ready are ignored.
  - stall is tied to 0, bus_err is tied to 0, and the WAIT state is absent.
  - SC advances every inc regardless of memory.

## Structure
- Package timing_pkg holds:
  - State enum {RUN, WAIT, HALT}.
  - Default SC_WIDTH and OPC_WIDTH constants.
  - A one-hot decode function shared by the t and d decoders.
- One sub-module: wait_timer. It implements the MAX_WAIT counter with start/clear and a timeout pulse, and is instantiated only under TIMING_WAIT_STATE_EN.

## Test plan
- Reset release, then inc each cycle for 16 cycles: t walks 0x0001→0x8000, then back to 0x0001, and overflow=1 from cycle 16.
- Sequence inc,inc,inc, then clr with inc held high: count 3→0, and overflow remains 0.
- ien=1, fgi=1 at count=3: r=1 next edge. A later clr clears r and count.
- mem_req=1 at count=1, mem_ready low for 2 cycles: stall=1 for 3 cycles, count holds 1, then count=2 after ready with inc.
- mem_req=1 with mem_ready never asserted (MAX_WAIT=8): after 8 wait cycles, halted=1, bus_err=1, t=0. A run pulse then restores t=0x0001 with bus_err still 1.
- halt_req at count=5: halted=1, t=0. run then gives count=0. reset asserted mid-WAIT gives all reset values immediately.

Source files
------------

// File: rtl/timing_pkg.sv
// Shared types and helpers for the timing sequencer: FSM state encoding,
// default widths and the one-hot decoder used for both T and D lines.
package timing_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int DEF_SC_WIDTH  = 4;
  localparam int DEF_OPC_WIDTH = 3;

  // Widest index the shared decoder supports; callers truncate the result.
  localparam int DEC_IDX_W = 8;
  localparam int DEC_LINES = 2 ** DEC_IDX_W;

  function automatic logic [DEC_LINES-1:0] onehot(input logic [DEC_IDX_W-1:0] idx);
    logic [DEC_LINES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/timing_sequencer_wait_timer.sv
// Wait-state timer: counts missing-ready cycles while a memory access is
// stalled and pulses timeout on the MAX_WAIT-th one.
module wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic start,
  output logic timeout
);

  localparam int CW = $clog2(MAX_WAIT);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clear) cnt <= '0;
    else if (start) cnt <= cnt + CW'(1);
  end

  // The counter never reaches MAX_WAIT: the owner leaves WAIT on this pulse.
  assign timeout = start && (cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter, T/D decoders, interrupt flag R and RUN/WAIT/HALT control.
// Define TIMING_WAIT_STATE_EN to build the memory wait-state handshake.
module timing_sequencer
  import timing_pkg::*;
#(
  parameter int SC_WIDTH  = DEF_SC_WIDTH,
  parameter int OPC_WIDTH = DEF_OPC_WIDTH,
  parameter int MAX_WAIT  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clr,
  input  logic                    halt_req,
  input  logic                    run,
  input  logic                    mem_req,
  input  logic                    mem_ready,
  input  logic                    ien,
  input  logic                    fgi,
  input  logic                    fgo,
  input  logic [OPC_WIDTH-1:0]    opcode,
  output logic [2**SC_WIDTH-1:0]  t,
  output logic [2**OPC_WIDTH-1:0] d,
  output logic [SC_WIDTH-1:0]     count,
  output logic                    r,
  output logic                    stall,
  output logic                    halted,
  output logic                    overflow,
  output logic                    bus_err
);

  localparam int NUM_T = 2 ** SC_WIDTH;
  localparam int NUM_D = 2 ** OPC_WIDTH;

  state_t              state, state_n;
  logic [SC_WIDTH-1:0] count_n;
  logic                r_n, ovf_n, berr_n;
  logic                mem_stall;
  logic                advance;

`ifdef TIMING_WAIT_STATE_EN
  logic timeout;

  assign mem_stall = (state == RUN) && mem_req && !mem_ready;
  assign stall     = (state == WAIT) || mem_stall;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != WAIT),
    .start   ((state == WAIT) && !mem_ready),
    .timeout (timeout)
  );
`else
  logic unused_mem;

  assign unused_mem = ^{mem_req, mem_ready, MAX_WAIT >= 2};
  assign mem_stall  = 1'b0;
  assign stall      = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    count_n = count;
    r_n     = r;
    ovf_n   = overflow;
    berr_n  = bus_err;
    advance = 1'b0;

    case (state)
      RUN: begin
        if (halt_req) begin
          state_n = HALT;
          count_n = '0;
        end else if (mem_stall) begin
          state_n = WAIT;
        end else begin
          advance = 1'b1;
        end
      end
`ifdef TIMING_WAIT_STATE_EN
      WAIT: begin
        if (mem_ready) begin
          state_n = RUN;
          advance = 1'b1;
        end else if (timeout) begin
          state_n = HALT;
          count_n = '0;
          berr_n  = 1'b1;
        end
      end
`endif
      HALT: begin
        count_n = '0;
        if (run && !halt_req) state_n = RUN;
      end
      default: begin
        state_n = RUN;
        count_n = '0;
      end
    endcase

    // clr beats inc; a wrap without clr is remembered until reset.
    if (advance) begin
      if (clr) begin
        count_n = '0;
      end else if (inc) begin
        count_n = count + SC_WIDTH'(1);
        if (count == '1) ovf_n = 1'b1;
      end
    end

    if ((state == RUN) && !mem_stall) begin
      if (!r && (count >= SC_WIDTH'(3)) && ien && (fgi || fgo)) r_n = 1'b1;
      else if (r && clr)                                        r_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      count    <= '0;
      r        <= 1'b0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      r        <= r_n;
      overflow <= ovf_n;
      bus_err  <= berr_n;
    end
  end

  assign halted = (state == HALT);
  assign t      = halted ? '0 : NUM_T'(onehot(DEC_IDX_W'(count)));
  assign d      = NUM_D'(onehot(DEC_IDX_W'(opcode)));

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench for timing_sequencer: a cycle-level reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_timing_sequencer;

  localparam int SC_W     = 4;
  localparam int OPC_W    = 3;
  localparam int MAX_WAIT = 8;
  localparam int NUM_T    = 16;
`ifdef TIMING_WAIT_STATE_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HALT = 2;

  logic             clk, rst_n;
  logic             inc, clr, halt_req, run, mem_req, mem_ready, ien, fgi, fgo;
  logic [OPC_W-1:0] opcode;
  logic [15:0]      t;
  logic [7:0]       d;
  logic [SC_W-1:0]  count;
  logic             r, stall, halted, overflow, bus_err;

  timing_sequencer #(.SC_WIDTH(SC_W), .OPC_WIDTH(OPC_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .halt_req(halt_req), .run(run),
    .mem_req(mem_req), .mem_ready(mem_ready), .ien(ien), .fgi(fgi), .fgo(fgo),
    .opcode(opcode), .t(t), .d(d), .count(count), .r(r), .stall(stall),
    .halted(halted), .overflow(overflow), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic inc, clr, halt_req, run, mem_req, mem_ready, ien, fgi, fgo;
    logic [OPC_W-1:0] opcode;
  } stim_t;

  typedef struct packed {
    logic [15:0] t;
    logic [7:0]  d;
    logic [3:0]  count;
    logic        r, stall, halted, overflow, bus_err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: plain integers following the behavioural rules.
  int m_state, m_count, m_wcnt;
  bit m_r, m_ovf, m_berr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_RUN; m_count = 0; m_wcnt = 0;
    m_r = 1'b0; m_ovf = 1'b0; m_berr = 1'b0;
  endtask

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    e.halted   = (m_state == M_HALT);
    e.t        = e.halted ? 16'h0 : 16'(1 << m_count);
    e.d        = 8'(1 << s.opcode);
    e.count    = 4'(m_count);
    e.r        = m_r;
    e.overflow = m_ovf;
    e.bus_err  = m_berr;
    e.stall    = WAIT_EN && ((m_state == M_WAIT) ||
                 ((m_state == M_RUN) && s.mem_req && !s.mem_ready));
    return e;
  endfunction

  task automatic model_advance(input stim_t s);
    if (s.clr) m_count = 0;
    else if (s.inc) begin
      if (m_count == NUM_T - 1) begin m_count = 0; m_ovf = 1'b1; end
      else m_count = m_count + 1;
    end
  endtask

  task automatic model_step(input stim_t s);
    bit stalled;
    bit r_next;
    stalled = WAIT_EN && s.mem_req && !s.mem_ready;
    r_next  = m_r;
    if (m_state == M_RUN && !stalled) begin
      if (!m_r && m_count >= 3 && s.ien && (s.fgi || s.fgo)) r_next = 1'b1;
      else if (m_r && s.clr) r_next = 1'b0;
    end
    case (m_state)
      M_RUN: begin
        if (s.halt_req) begin m_state = M_HALT; m_count = 0; end
        else if (stalled) begin m_state = M_WAIT; m_wcnt = 0; end
        else model_advance(s);
      end
      M_WAIT: begin
        if (s.mem_ready) begin m_state = M_RUN; model_advance(s); end
        else begin
          m_wcnt = m_wcnt + 1;
          if (m_wcnt == MAX_WAIT) begin m_state = M_HALT; m_count = 0; m_berr = 1'b1; end
        end
      end
      default: begin
        m_count = 0;
        if (s.run && !s.halt_req) m_state = M_RUN;
      end
    endcase
    m_r = r_next;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s        = '0;
    s.opcode = 3'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    inc = s.inc; clr = s.clr; halt_req = s.halt_req; run = s.run;
    mem_req = s.mem_req; mem_ready = s.mem_ready;
    ien = s.ien; fgi = s.fgi; fgo = s.fgo; opcode = s.opcode;
  endtask

  // One clock of stimulus: inputs change just after the edge, the expected
  // outputs for this cycle are queued, then the model steps to the next edge.
  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    sb_q.push_back(model_out(s));
    model_step(s);
  endtask

  task automatic drive_inc(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = idle(); s.inc = 1'b1;
      drive(s);
    end
  endtask

  task automatic check_reset_values();
    check("rst_count",    32'(count),    32'd0);
    check("rst_t",        32'(t),        32'h1);
    check("rst_r",        32'(r),        32'd0);
    check("rst_halted",   32'(halted),   32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_bus_err",  32'(bus_err),  32'd0);
    check("rst_stall",    32'(stall),    32'd0);
    check("rst_d",        32'(d),        32'(1 << opcode));
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must snap back at once.
  task automatic do_reset();
    @(posedge clk);
    #2;
    apply(idle());
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("t",        32'(t),        32'(e.t));
        check("d",        32'(d),        32'(e.d));
        check("count",    32'(count),    32'(e.count));
        check("r",        32'(r),        32'(e.r));
        check("stall",    32'(stall),    32'(e.stall));
        check("halted",   32'(halted),   32'(e.halted));
        check("overflow", 32'(overflow), 32'(e.overflow));
        check("bus_err",  32'(bus_err),  32'(e.bus_err));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    stim_t s;
    rst_n = 1'b0;
    apply(idle());
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_reset_values();
    rst_n = 1'b1;

    // T walk through all 16 states and wrap into overflow.
    drive_inc(17);
    drive(idle());

    // clr wins over a simultaneous inc and does not flag overflow.
    do_reset();
    drive_inc(3);
    s = idle(); s.clr = 1'b1; s.inc = 1'b1; drive(s);
    drive(idle());

    // Interrupt flag set at count 3, cleared by a later clr.
    drive_inc(3);
    s = idle(); s.ien = 1'b1; s.fgi = 1'b1; drive(s);
    drive(idle());
    drive_inc(1);
    s = idle(); s.clr = 1'b1; drive(s);
    drive(idle());

    // Memory access with two missing ready cycles.
    do_reset();
    drive_inc(1);
    s = idle(); s.mem_req = 1'b1; s.inc = 1'b1; drive(s);
    s = idle(); s.inc = 1'b1; drive(s);
    s = idle(); s.mem_ready = 1'b1; s.inc = 1'b1; drive(s);
    drive(idle());

    // Memory never ready: timeout into HALT, then run with bus_err kept.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.mem_req = 1'b1; s.inc = 1'b1; drive(s);
    end
    s = idle(); s.run = 1'b1; drive(s);
    drive(idle());
    drive_inc(2);

    // HALT at count 5, run blocked by halt_req, then released.
    do_reset();
    drive_inc(5);
    s = idle(); s.halt_req = 1'b1; s.inc = 1'b1; drive(s);
    s = idle(); s.inc = 1'b1; drive(s);
    s = idle(); s.run = 1'b1; s.halt_req = 1'b1; drive(s);
    s = idle(); s.run = 1'b1; drive(s);
    drive_inc(2);

    // halt_req beats a simultaneous memory stall, then reset mid-WAIT.
    s = idle(); s.halt_req = 1'b1; s.mem_req = 1'b1; drive(s);
    s = idle(); s.run = 1'b1; drive(s);
    s = idle(); s.mem_req = 1'b1; drive(s);
    drive(idle());
    do_reset();

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      s           = idle();
      s.inc       = ($urandom_range(0, 9) < 7);
      s.clr       = ($urandom_range(0, 9) < 1);
      s.halt_req  = ($urandom_range(0, 39) == 0);
      s.run       = ($urandom_range(0, 9) < 3);
      s.mem_req   = ($urandom_range(0, 9) < 2);
      s.mem_ready = ($urandom_range(0, 9) < 5);
      s.ien       = ($urandom_range(0, 1) == 1);
      s.fgi       = ($urandom_range(0, 3) == 0);
      s.fgo       = ($urandom_range(0, 3) == 0);
      drive(s);
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
